// File: rtl/conv_pkg.sv
// Shared types and helpers for the sliding-window convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    ARMED = 3'd1,
    MAC   = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_KER = 1;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned pix_w,
                                            input int unsigned ker_w,
                                            input int unsigned ker_dim);
    return pix_w + ker_w + int'($clog2(ker_dim * ker_dim)) + 1;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Registered signed multiply-accumulate: unsigned pixel times signed coefficient.
module conv_mac_unit #(
  parameter int unsigned PIX_W = 1,
  parameter int unsigned KER_W = 4,
  parameter int unsigned ACC_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [PIX_W-1:0]        pix,
  input  logic signed [KER_W-1:0] coef,
  output logic signed [ACC_W-1:0] acc
);

  localparam int unsigned PROD_W = PIX_W + KER_W + 1;

  logic signed [PROD_W-1:0] prod;

  // Pixel is zero-extended so it always multiplies as a non-negative value.
  always_comb prod = PROD_W'($signed({1'b0, pix})) * PROD_W'(coef);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_window_engine.sv
// Valid-mode 2-D convolution, one MAC per cycle, streamed over valid/ready.
// Build option CONV_RELU_EN clamps negative results to zero.
module conv_window_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_DIM = 6,
  parameter int unsigned KER_DIM = 3,
  parameter int unsigned PIX_W   = 1,
  parameter int unsigned KER_W   = 4,
  parameter int unsigned ACC_W   = acc_width(PIX_W, KER_W, KER_DIM)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       row_valid,
  input  logic [IMG_DIM*PIX_W-1:0]                   row_data,
  output logic                                       row_ready,
  input  logic                                       ker_we,
  input  logic [idx_width(KER_DIM*KER_DIM)-1:0]      ker_addr,
  input  logic signed [KER_W-1:0]                    ker_data,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [ACC_W-1:0]                    out_data,
  output logic [idx_width(IMG_DIM)-1:0]              out_row,
  output logic [idx_width(IMG_DIM)-1:0]              out_col,
  output logic                                       done
);

  localparam int unsigned KK   = KER_DIM * KER_DIM;
  localparam int unsigned OD   = IMG_DIM - KER_DIM + 1;
  localparam int unsigned RC_W = idx_width(IMG_DIM);
  localparam int unsigned KA_W = idx_width(KK);
  localparam int unsigned KI_W = $clog2(KK + 1);

  state_t state, state_d;

  logic [PIX_W-1:0]        img [IMG_DIM][IMG_DIM];
  logic signed [KER_W-1:0] ker [KK];
  logic [RC_W-1:0]         row_cnt;
  logic [RC_W-1:0]         win_r, win_c, kr, kc;
  logic [KI_W-1:0]         k_idx;

  logic row_ready_d, busy_d, out_valid_d, done_d;
  logic row_we, ker_wr, mac_clr, mac_en, out_load, win_rst, win_adv;
  logic last_row, last_win;

  logic [RC_W-1:0]         pix_r, pix_c;
  logic [PIX_W-1:0]        mac_pix;
  logic signed [KER_W-1:0] mac_coef;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] result_c;

  assign last_row = (row_cnt == RC_W'(IMG_DIM - 1));
  assign last_win = (win_r == RC_W'(OD - 1)) && (win_c == RC_W'(OD - 1));
  assign ker_wr   = ker_we && !busy && (32'(ker_addr) < KK);

  always_comb begin
    pix_r    = win_r + kr;
    pix_c    = win_c + kc;
    mac_pix  = img[pix_r][pix_c];
    mac_coef = ker[KA_W'(k_idx)];
  end

`ifdef CONV_RELU_EN
  assign result_c = acc[ACC_W-1] ? '0 : acc;
`else
  assign result_c = acc;
`endif

  conv_mac_unit #(
    .PIX_W (PIX_W),
    .KER_W (KER_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .pix   (mac_pix),
    .coef  (mac_coef),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= LOAD;
    else       state <= state_d;
  end

  // Next state, next registered outputs and datapath strobes.
  always_comb begin
    state_d     = state;
    row_ready_d = row_ready;
    busy_d      = busy;
    out_valid_d = out_valid;
    done_d      = 1'b0;
    row_we      = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    out_load    = 1'b0;
    win_rst     = 1'b0;
    win_adv     = 1'b0;
    unique case (state)
      LOAD, FIN: begin
        state_d     = LOAD;
        busy_d      = 1'b0;
        row_ready_d = 1'b1;
        if (row_valid && row_ready) begin
          row_we = 1'b1;
          if (last_row) begin
            state_d     = ARMED;
            row_ready_d = 1'b0;
          end
        end
      end
      ARMED: begin
        row_ready_d = 1'b0;
        if (start) begin
          state_d = MAC;
          busy_d  = 1'b1;
          mac_clr = 1'b1;
          win_rst = 1'b1;
        end
      end
      MAC: begin
        // One extra step after the last term lets the accumulator settle.
        if (k_idx == KI_W'(KK)) begin
          out_load    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          mac_en = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_win) begin
            state_d     = FIN;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            row_ready_d = 1'b1;
          end else begin
            state_d = MAC;
            mac_clr = 1'b1;
            win_adv = 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      row_ready <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      row_cnt   <= '0;
      win_r     <= '0;
      win_c     <= '0;
      kr        <= '0;
      kc        <= '0;
      k_idx     <= '0;
      for (int r = 0; r < IMG_DIM; r++)
        for (int c = 0; c < IMG_DIM; c++)
          img[r][c] <= '0;
      for (int k = 0; k < KK; k++)
        ker[k] <= KER_W'(DEFAULT_KER);
    end else begin
      row_ready <= row_ready_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
      done      <= done_d;

      if (row_we) begin
        for (int c = 0; c < IMG_DIM; c++)
          img[row_cnt][c] <= row_data[c*PIX_W +: PIX_W];
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end

      if (ker_wr) ker[ker_addr] <= ker_data;

      if (win_rst) begin
        win_r <= '0;
        win_c <= '0;
      end else if (win_adv) begin
        if (win_c == RC_W'(OD - 1)) begin
          win_c <= '0;
          win_r <= win_r + 1'b1;
        end else begin
          win_c <= win_c + 1'b1;
        end
      end

      // Kernel walk in raster order alongside the accumulator.
      if (mac_clr) begin
        k_idx <= '0;
        kr    <= '0;
        kc    <= '0;
      end else if (mac_en) begin
        k_idx <= k_idx + 1'b1;
        if (kc == RC_W'(KER_DIM - 1)) begin
          kc <= '0;
          kr <= kr + 1'b1;
        end else begin
          kc <= kc + 1'b1;
        end
      end

      if (out_load) begin
        out_data <= result_c;
        out_row  <= win_r;
        out_col  <= win_c;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// Scoreboard bench for conv_window_engine; honours CONV_RELU_EN when defined.
module tb_conv_window_engine;

  localparam int IMG = 6;
  localparam int KER = 3;
  localparam int KK  = KER * KER;
  localparam int OD  = IMG - KER + 1;

  typedef struct {
    int d;
    int r;
    int c;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              row_valid;
  logic [IMG-1:0]    row_data;
  logic              row_ready;
  logic              ker_we;
  logic [3:0]        ker_addr;
  logic signed [3:0] ker_data;
  logic              start;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic signed [9:0] out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc;
  bit   first_pending = 0;
  bit   frame_done    = 0;
  int   done_cnt      = 0;
  int   tb_img [IMG][IMG];
  int   tb_ker [KK];
  exp_t exp_q [$];

  conv_window_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_ready (row_ready),
    .ker_we    (ker_we),
    .ker_addr  (ker_addr),
    .ker_data  (ker_data),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consumer side: pop an expectation per accepted output.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && first_pending) begin
      check_eq("latency", cyc - start_cyc, KK + 1);
      first_pending = 0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", int'(out_data), e.d);
        check_eq("out_row", int'(out_row), e.r);
        check_eq("out_col", int'(out_col), e.c);
      end
    end
    if (done) begin
      done_cnt++;
      frame_done = 1;
    end
  end

  task automatic set_image(input int mode);
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        tb_img[r][c] = (mode == 0) ? 1 : ((r + c) % 2);
  endtask

  task automatic load_rows(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      check_eq("row_ready_load", int'(row_ready), 1);
      row_valid = 1'b1;
      for (int c = 0; c < IMG; c++) row_data[c] = tb_img[r][c][0];
      step();
    end
    row_valid = 1'b0;
  endtask

  task automatic write_ker(input int addr, input int val);
    ker_we   = 1'b1;
    ker_addr = 4'(addr);
    ker_data = 4'(val);
    step();
    ker_we = 1'b0;
    tb_ker[addr] = val;
  endtask

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < OD; r++)
      for (int c = 0; c < OD; c++) begin
        e.d = 0;
        for (int i = 0; i < KER; i++)
          for (int j = 0; j < KER; j++)
            e.d += tb_img[r+i][c+j] * tb_ker[i*KER+j];
`ifdef CONV_RELU_EN
        if (e.d < 0) e.d = 0;
`endif
        e.r = r;
        e.c = c;
        exp_q.push_back(e);
      end
  endtask

  task automatic pulse_start();
    start         = 1'b1;
    start_cyc     = cyc + 1;
    first_pending = 1;
    step();
    start    = 1'b0;
    ker_we   = 1'b0;
  endtask

  task automatic run_frame(input bit do_stall, input bit do_poke,
                           input bit simul_we, input int simul_val);
    int t = 0;
    bit stalled = 0;
    int held;
    if (simul_we) begin
      ker_we     = 1'b1;
      ker_addr   = 4'(KK - 1);
      ker_data   = 4'(simul_val);
      tb_ker[KK-1] = simul_val;
    end
    push_expected();
    frame_done = 0;
    done_cnt   = 0;
    pulse_start();
    if (do_poke) begin
      repeat (3) step();
      ker_we   = 1'b1;
      ker_addr = 4'd4;
      ker_data = -4'sd3;
      start    = 1'b1;
      step();
      ker_we = 1'b0;
      start  = 1'b0;
    end
    while (!frame_done && t < 3000) begin
      if (do_stall && !stalled && out_valid && out_row == 3'd1 && out_col == 3'd2) begin
        stalled   = 1;
        held      = int'(out_data);
        out_ready = 1'b0;
        repeat (5) begin
          step();
          check_eq("stall_valid", int'(out_valid), 1);
          check_eq("stall_data", int'(out_data), held);
        end
        out_ready = 1'b1;
      end
      step();
      t++;
    end
    check_eq("frame_done", int'(frame_done), 1);
    repeat (2) step();
    check_eq("done_pulses", done_cnt, 1);
    check_eq("busy_after", int'(busy), 0);
    check_eq("row_ready_after", int'(row_ready), 1);
    check_eq("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_row_ready"}, int'(row_ready), 1);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    check_eq({tag, "_out_data"}, int'(out_data), 0);
    check_eq({tag, "_out_row"}, int'(out_row), 0);
    check_eq({tag, "_out_col"}, int'(out_col), 0);
    check_eq({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int t;
    rst_n     = 1'b1;
    row_valid = 1'b0;
    row_data  = '0;
    ker_we    = 1'b0;
    ker_addr  = '0;
    ker_data  = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < KK; k++) tb_ker[k] = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b0;
    step();

    // All-ones image with the default all +1 kernel.
    set_image(0);
    load_rows(0, IMG);
    check_eq("armed_row_ready", int'(row_ready), 0);
    run_frame(0, 0, 0, 0);

    // Checkerboard through a centre-only kernel, with a stalled consumer.
    for (int k = 0; k < KK; k++) write_ker(k, (k == 4) ? 1 : 0);
    set_image(1);
    load_rows(0, IMG);
    run_frame(1, 0, 0, 0);

    // Early start on a partial image, then a kernel write while busy.
    load_rows(0, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_eq("partial_busy", int'(busy), 0);
    check_eq("partial_row_ready", int'(row_ready), 1);
    load_rows(4, IMG);
    run_frame(0, 1, 0, 0);

    // Negative kernel; last coefficient written together with start; extra row ignored.
    for (int k = 0; k < KK - 1; k++) write_ker(k, -1);
    set_image(0);
    load_rows(0, IMG);
    row_valid = 1'b1;
    row_data  = '0;
    check_eq("extra_row_ready", int'(row_ready), 0);
    repeat (2) step();
    row_valid = 1'b0;
    run_frame(0, 0, 1, -1);

    // Reset in the middle of window (2,1).
    load_rows(0, IMG);
    push_expected();
    frame_done = 0;
    done_cnt   = 0;
    pulse_start();
    t = 0;
    while (!(out_valid && out_row == 3'd2 && out_col == 3'd0) && t < 1000) begin
      step();
      t++;
    end
    check_eq("reach_2_0", int'(out_valid && out_row == 3'd2 && out_col == 3'd0), 1);
    step();
    repeat (3) step();
    check_eq("mid_busy", int'(busy), 1);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    first_pending = 0;
    repeat (2) step();
    rst_n = 1'b0;
    repeat (4) step();
    check_eq("midrst_no_done", done_cnt, 0);
    check_eq("midrst_row_ready", int'(row_ready), 1);

    // Kernel must be back to all +1.
    for (int k = 0; k < KK; k++) tb_ker[k] = 1;
    set_image(0);
    load_rows(0, IMG);
    run_frame(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/conv_window_engine.md
Name: conv_window_engine

Overview:
- Parametrised successor to the switch-driven 6x6 conv layer. Loads an IMG_DIM x IMG_DIM image row by row and holds a writable KER_DIM x KER_DIM signed kernel.
- Computes the full valid-mode 2-D convolution (no padding, stride 1) with one MAC per cycle.
- Streams each output pixel over a valid/ready port. Sits between the button/row loader and the display/readout logic.

Parameters:
- IMG_DIM, 6, image rows and columns.
- KER_DIM, 3, kernel rows and columns; must satisfy 1 <= KER_DIM <= IMG_DIM.
- PIX_W, 1, unsigned pixel width.
- KER_W, 4, signed kernel coefficient width.
- ACC_W, PIX_W+KER_W+$clog2(KER_DIM*KER_DIM)+1, signed accumulator/output width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- row_valid  in  1  image row offered
- row_data  in  IMG_DIM*PIX_W  row pixels; column c at bits [c*PIX_W +: PIX_W]
- row_ready  out  1  loader can accept a row
- ker_we  in  1  kernel coefficient write strobe
- ker_addr  in  $clog2(KER_DIM*KER_DIM)  coefficient index, r*KER_DIM+c
- ker_data  in  KER_W  signed coefficient
- start  in  1  begin convolution
- busy  out  1  computation in progress
- out_valid  out  1  output pixel valid
- out_ready  in  1  consumer accepts pixel
- out_data  out  ACC_W  signed convolution result
- out_row  out  $clog2(IMG_DIM)  output row index
- out_col  out  $clog2(IMG_DIM)  output column index
- done  out  1  one-cycle pulse after the last output is accepted

Behaviour:
- Reset: rst_n, asynchronous, active-high; clock clk, rising edge.
- On reset:
  - row count 0; image cleared to 0; all kernel coefficients = +1.
  - row_ready=1, busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, done=0.
  - FSM to LOAD.
- OD = IMG_DIM-KER_DIM+1 (output dimension).
- FSM states: LOAD, ARMED, MAC, HOLD, FIN.
- LOAD:
  - row_ready=1. A row is written into row[count] on row_valid&&row_ready, then count increments.
  - After IMG_DIM rows, go to ARMED; row_ready=0.
- ARMED:
  - row_ready=0; further row_valid is ignored (image full).
  - start moves to MAC with window (0,0), accumulator cleared, busy=1.
- start outside ARMED (LOAD, partial image, or while busy) is ignored; no error flag.
- MAC:
  - Takes KER_DIM*KER_DIM cycles; index k = 0..K²-1, raster order.
  - acc += $signed({1'b0,pixel}) * kernel[k], with full sign extension to ACC_W. No overflow is possible at ACC_W.
  - After the last term: out_data, out_row and out_col are registered and out_valid=1; go to HOLD.
- Latency: first out_valid rises exactly KER_DIM*KER_DIM+1 cycles after the clk edge that samples start.
- HOLD:
  - out_data, out_row, out_col and out_valid are held stable until out_valid&&out_ready.
  - On that handshake, out_valid drops in the same edge, and the window advances column-first, wrapping col OD-1 -> 0 with row+1.
  - If a next window exists, go to MAC. The next out_valid rises K²+1 cycles after the handshake.
  - After the window (OD-1,OD-1) is accepted, go to FIN.
- FIN:
  - done=1 for exactly one cycle, busy=0, row count 0, row_ready=1, then LOAD.
  - The image is re-loaded per frame; the kernel is retained.
- Kernel writes:
  - ker_we is honoured only when busy=0 and takes effect on the next edge.
  - ker_we while busy=1 is dropped. ker_addr >= K² is ignored.
- Simultaneous events:
  - row_valid on the same cycle as the LOAD->ARMED transition is not accepted (row_ready already 0 for the 7th row).
  - start and ker_we in the same ARMED cycle: the kernel write lands and the MAC uses the new coefficient.
- Reset mid-operation: asserting rst_n in any state restores all reset values asynchronously. Any partial output is lost and no done pulse is issued.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: a negative result is clamped to 0 before registering out_data; non-negative results pass unchanged.
- Undefined: signed results pass unmodified. Port list is identical in both builds.

Decomposition:
- Package conv_pkg:
  - FSM state enum (LOAD, ARMED, MAC, HOLD, FIN).
  - Function computing ACC_W from parameters.
  - Constant default kernel value (+1).
- One natural sub-module, conv_mac_unit: registered signed multiply-accumulate with clear/enable, width ACC_W.
- FSM, image store, kernel store and output register stay in the top module.

Test Plan:
- All-ones 6x6 image, reset kernel (all +1), start, out_ready=1 -> 16 outputs, each 9, in raster order (0,0)..(3,3); done pulses once; first out_valid 10 cycles after start.
- Checkerboard image, kernel with only the centre coefficient (index 4) = +1, others 0 -> out_data equals image[r+1][c+1] for all 16 outputs.
- Hold out_ready=0 for 5 cycles on output (1,2) -> out_valid and out_data stay constant, no output dropped or duplicated, total still 16.
- start after only 4 rows, and ker_we during MAC -> start ignored (busy stays 0); kernel write has no effect on results.
- All-ones image, kernel all -1 -> every output -9 without CONV_RELU_EN; every output 0 with CONV_RELU_EN.
- Assert rst_n during MAC of window (2,1) -> all outputs return to reset values; kernel back to all +1; row_ready=1; no done.
